iot_event_arbiter: RTL and testbench
====================================

IOT_EVENT_ARBITER -- requirements
Module: iot_event_arbiter

Interface
REQ-001 Parameter N_DEV SHALL default to 4 and set the number of IoT device requesters.
REQ-002 Parameter CNT_W SHALL default to 8 and set the width of the active-device count, matching the monitor counter width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port req  input  N_DEV  SHALL carry per-device event requests, held high until ack or nack.
REQ-006 Port dir  input  N_DEV  SHALL give per-device direction: 1 = connect, 0 = disconnect; sampled with req at grant.
REQ-007 Port ack  output  N_DEV  SHALL be a one-hot, one-cycle pulse: event accepted.
REQ-008 Port nack  output  N_DEV  SHALL be a one-hot, one-cycle pulse: event rejected.
REQ-009 Port on_off  output  1  SHALL be the monitor counter enable.
REQ-010 Port change  output  1  SHALL be the monitor counter direction: 1 = up, 0 = down.
REQ-011 Port active  output  N_DEV  SHALL expose the per-device connected flags.
REQ-012 Port active_count  output  CNT_W  SHALL be the shadow count of set active flags.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE and RECOVER.
REQ-014 Transitions: IDLE -> ISSUE when any req is high, otherwise stay in IDLE; ISSUE -> RECOVER unconditionally; RECOVER -> IDLE unconditionally.
REQ-015 In IDLE, the block SHALL grant one requester round-robin, searching from the device after the last granted one (device 0 first after reset).
REQ-016 In IDLE, the block SHALL latch the granted index and its dir.
REQ-017 Requesters not granted SHALL keep req high and SHALL be served in later IDLE cycles.
REQ-018 An event SHALL be valid when it is a connect with active[g]=0 and active_count < 2^CNT_W-1, or a disconnect with active[g]=1.
REQ-019 For a valid event in ISSUE, the block SHALL drive on_off=1, change=latched dir and ack[g]=1 for exactly that cycle.
REQ-020 For a valid event, active[g] and active_count (+1 or -1) SHALL update at the edge that ends ISSUE.
REQ-021 For an invalid event in ISSUE, the block SHALL assert nack[g]=1 and keep on_off=0; active and active_count SHALL be unchanged.
REQ-022 In RECOVER, ack, nack and on_off SHALL be 0 and req SHALL be ignored, giving the requester one cycle to drop req.
REQ-023 Latency SHALL be exactly 1 cycle from the IDLE grant to ISSUE, with a maximum throughput of one event per 3 cycles.
REQ-024 Outside ISSUE, on_off SHALL be 0 and change SHALL be 1.
REQ-025 active_count SHALL always equal the population count of active and SHALL never wrap.
REQ-026 A dir change while a request is pending SHALL take effect only if the device is not yet granted.

Reset
REQ-027 When rst=1 at a clock edge, the next state SHALL be IDLE with the round-robin pointer at device 0, active=0 and active_count=0.
REQ-028 When rst=1 at a clock edge, the outputs in the next cycle SHALL be ack=0, nack=0, on_off=0 and change=1.
REQ-029 rst asserted during ISSUE or RECOVER SHALL abort the event with no ack or nack in the following cycle and no flag update.

Structure
REQ-030 Shared package iot_mon_pkg SHALL hold the state enum (IDLE/ISSUE/RECOVER) and the default constants N_DEV=4 and CNT_W=8.
REQ-031 Round-robin selection SHALL be sub-module rr_arbiter, which takes req and the last-grant pointer and returns a one-hot grant plus a grant-valid flag.
REQ-032 The monitor counter SHALL be instantiated outside this block and driven by on_off and change; clk and rst are shared.

Verification
REQ-033 Scenario: reset, then req[0]=1, dir[0]=1 -> cycle+1 on_off=1, change=1, ack[0]=1; then active=0001, active_count=1, and the monitor counter_out=1.
REQ-034 Scenario: req[3:1]=111, all connect, from active=0001 -> ack[1], ack[2], ack[3] at 3-cycle spacing, in that order; active_count=4.
REQ-035 Scenario: device 2 connects while already active -> nack[2]; on_off stays 0; active_count is unchanged.
REQ-036 Scenario: device 0 disconnects while active -> on_off=1, change=0, active_count decrements by 1.
REQ-036 (cont.) Then device 0 disconnects again -> nack[0] and no counter pulse.
REQ-037 Scenario: rst=1 in the ISSUE cycle -> no ack or nack, on_off=0 next cycle; active=0 and active_count=0.
REQ-038 Scenario: req[0] and req[1] held high with dir toggling -> grants alternate 0,1,0,1; active_count tracks the monitor counter_out every cycle.

Source files
------------

// File: rtl/iot_mon_pkg.sv
// rtl/iot_mon_pkg.sv - shared state encoding and default sizes for the IoT event arbiter
package iot_mon_pkg;

    localparam int N_DEV_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin requester select, search begins at start and wraps
module rr_arbiter #(
    parameter int N_DEV = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_DEV-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [N_DEV-1:0] grant,
    output logic             valid
);

    localparam int IW1 = IDX_W + 1;

    logic [IW1-1:0] idx;

    // One extra index bit lets start+i exceed N_DEV before folding back.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_DEV; i++) begin
            idx = IW1'(start) + IW1'(i);
            if (idx >= IW1'(N_DEV)) begin
                idx = idx - IW1'(N_DEV);
            end
            if (!valid && req[idx[IDX_W-1:0]]) begin
                grant[idx[IDX_W-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iot_event_arbiter.sv
// rtl/iot_event_arbiter.sv - grants one device event at a time and drives the external monitor counter
module iot_event_arbiter
    import iot_mon_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] req,
    input  logic [N_DEV-1:0] dir,
    output logic [N_DEV-1:0] ack,
    output logic [N_DEV-1:0] nack,
    output logic             on_off,
    output logic             change,
    output logic [N_DEV-1:0] active,
    output logic [CNT_W-1:0] active_count
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] g_idx;
    logic             g_dir;
    logic [N_DEV-1:0] arb_grant;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic             ev_valid;

    rr_arbiter #(
        .N_DEV (N_DEV),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (req),
        .start (ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (arb_grant[i]) begin
                arb_idx = IDX_W'(i);
            end
        end
    end

    // ptr holds the first device to consider, i.e. one past the last grant.
    assign ptr_nxt = (arb_idx == IDX_W'(N_DEV - 1)) ? '0 : arb_idx + 1'b1;

    // A connect is refused when already connected or the count is saturated.
    assign ev_valid = g_dir ? (!active[g_idx] && (active_count != CNT_MAX))
                            : active[g_idx];

    always_comb begin
        state_nxt = state;
        ack       = '0;
        nack      = '0;
        on_off    = 1'b0;
        change    = 1'b1;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RECOVER;
                // A reset landing on the issue cycle aborts the event outright.
                if (!rst) begin
                    if (ev_valid) begin
                        on_off     = 1'b1;
                        change     = g_dir;
                        ack[g_idx] = 1'b1;
                    end else begin
                        nack[g_idx] = 1'b1;
                    end
                end
            end
            RECOVER: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            g_idx        <= '0;
            g_dir        <= 1'b0;
            active       <= '0;
            active_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_valid) begin
                g_idx <= arb_idx;
                g_dir <= dir[arb_idx];
                ptr   <= ptr_nxt;
            end
            if (state == ISSUE && ev_valid) begin
                active[g_idx] <= g_dir;
                active_count  <= g_dir ? active_count + 1'b1 : active_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iot_event_arbiter.sv
// tb/tb_iot_event_arbiter.sv - directed self-checking bench for iot_event_arbiter
module tb_iot_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] dir;
    logic [3:0] ack;
    logic [3:0] nack;
    logic       on_off;
    logic       change;
    logic [3:0] active;
    logic [7:0] active_count;

    logic [7:0] mon_cnt;
    int         n_assert;
    int         n_fail;

    iot_event_arbiter #(
        .N_DEV (4),
        .CNT_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .dir          (dir),
        .ack          (ack),
        .nack         (nack),
        .on_off       (on_off),
        .change       (change),
        .active       (active),
        .active_count (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External monitor counter driven by on_off/change.
    always @(posedge clk) begin
        if (rst) begin
            mon_cnt <= 8'd0;
        end else if (on_off) begin
            mon_cnt <= change ? mon_cnt + 8'd1 : mon_cnt - 8'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        dir      = 4'b0000;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_nack", 32'(nack), 32'h0);
        chk("rst_on_off", 32'(on_off), 32'h0);
        chk("rst_change", 32'(change), 32'h1);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_count", 32'(active_count), 32'h0);

        // Device 0 connects.
        req = 4'b0001;
        dir = 4'b0001;
        tick();
        chk("s1_on_off", 32'(on_off), 32'h1);
        chk("s1_change", 32'(change), 32'h1);
        chk("s1_ack", 32'(ack), 32'h1);
        chk("s1_nack", 32'(nack), 32'h0);
        req = 4'b0000;
        tick();
        chk("s1_recover_ack", 32'(ack), 32'h0);
        chk("s1_recover_on_off", 32'(on_off), 32'h0);
        chk("s1_active", 32'(active), 32'h1);
        chk("s1_count", 32'(active_count), 32'h1);
        chk("s1_mon", 32'(mon_cnt), 32'h1);
        tick();

        // Devices 1..3 connect together; served in order, 3 cycles apart.
        req = 4'b1110;
        dir = 4'b1110;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("s2_ack_dev%0d", k), 32'(ack), 32'(1 << k));
            req[k] = 1'b0;
            tick();
            chk($sformatf("s2_quiet_dev%0d", k), 32'(ack), 32'h0);
            tick();
        end
        chk("s2_active", 32'(active), 32'hf);
        chk("s2_count", 32'(active_count), 32'h4);
        chk("s2_mon", 32'(mon_cnt), 32'h4);

        // Device 2 connects again while active: rejected.
        req = 4'b0100;
        dir = 4'b0100;
        tick();
        chk("s3_nack", 32'(nack), 32'h4);
        chk("s3_ack", 32'(ack), 32'h0);
        chk("s3_on_off", 32'(on_off), 32'h0);
        req = 4'b0000;
        tick();
        chk("s3_count", 32'(active_count), 32'h4);
        chk("s3_mon", 32'(mon_cnt), 32'h4);
        tick();

        // Device 0 disconnects, then tries again.
        req = 4'b0001;
        dir = 4'b0000;
        tick();
        chk("s4_on_off", 32'(on_off), 32'h1);
        chk("s4_change", 32'(change), 32'h0);
        chk("s4_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        tick();
        chk("s4_count", 32'(active_count), 32'h3);
        chk("s4_active", 32'(active), 32'he);
        chk("s4_mon", 32'(mon_cnt), 32'h3);
        tick();
        req = 4'b0001;
        tick();
        chk("s4b_nack", 32'(nack), 32'h1);
        chk("s4b_on_off", 32'(on_off), 32'h0);
        req = 4'b0000;
        tick();
        chk("s4b_count", 32'(active_count), 32'h3);
        chk("s4b_mon", 32'(mon_cnt), 32'h3);
        tick();

        // Reset arrives during the issue cycle of a valid disconnect.
        req = 4'b0010;
        dir = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        chk("s5_ack", 32'(ack), 32'h0);
        chk("s5_nack", 32'(nack), 32'h0);
        chk("s5_on_off", 32'(on_off), 32'h0);
        chk("s5_change", 32'(change), 32'h1);
        chk("s5_active", 32'(active), 32'h0);
        chk("s5_count", 32'(active_count), 32'h0);
        rst = 1'b0;
        req = 4'b0000;
        tick();

        // Devices 0 and 1 held requesting, direction flipped per pair of events.
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            dir = (k < 2) ? 4'b0011 : 4'b0000;
            tick();
            chk($sformatf("s6_ack_ev%0d", k), 32'(ack), 32'(1 << (k % 2)));
            chk($sformatf("s6_change_ev%0d", k), 32'(change), (k < 2) ? 32'h1 : 32'h0);
            chk($sformatf("s6_track_issue_ev%0d", k), 32'(active_count), 32'(mon_cnt));
            tick();
            chk($sformatf("s6_count_ev%0d", k), 32'(active_count), (k == 1) ? 32'h2 : ((k == 3) ? 32'h0 : 32'h1));
            chk($sformatf("s6_track_rec_ev%0d", k), 32'(active_count), 32'(mon_cnt));
            tick();
            chk($sformatf("s6_track_idle_ev%0d", k), 32'(active_count), 32'(mon_cnt));
        end
        req = 4'b0000;
        tick();
        chk("s6_active", 32'(active), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
